// File: rtl/operand_select_stage_if.sv
// Operand select handshake bundle: request side (selects, sources)
// and response side (registered operand pair, status flags).
interface operand_select_stage_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
);
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [NSRC-1:0]       src_valid;
  logic [SELW-1:0]       asel;
  logic [SELW-1:0]       bsel;
  logic                  swap;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      ain;
  logic [WIDTH-1:0]      bin;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
  logic                  stall_timeout;

  modport master (
    output src_bus, src_valid, asel, bsel, swap,
    output in_valid, out_ready,
    input  in_ready, ain, bin, out_valid,
    input  sel_err, stall_timeout
  );

  modport slave (
    input  src_bus, src_valid, asel, bsel, swap,
    input  in_valid, out_ready,
    output in_ready, ain, bin, out_valid,
    output sel_err, stall_timeout
  );
endinterface

// File: rtl/operand_select_stage.sv
// Registered A/B operand selector with valid/ready capture,
// source-valid stalling and a saturating stall counter.
module operand_select_stage #(
  parameter int WIDTH       = 16,
  parameter int NSRC        = 4,
  parameter int SELW        = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int CNTW        = 8,
  parameter int STALL_LIMIT = 64
) (
  input logic clk,
  input logic rst_n,
  operand_select_stage_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [CNTW-1:0] CMAX  = '1;
  localparam logic [CNTW-1:0] LIMIT = CNTW'(STALL_LIMIT);

  logic [WIDTH-1:0] aval, bval;
  logic             a_ok, b_ok;
  logic             a_bad, b_bad;
  logic             srcs_ok, space, accept, stall;

  logic [WIDTH-1:0] ain_q, bin_q;
  logic             ov_q, err_q;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  stall_cnt, cnt_d;

  // Out-of-range selects read as an always-valid zero source.
  always_comb begin
    aval  = '0;
    bval  = '0;
    a_ok  = 1'b1;
    b_ok  = 1'b1;
    a_bad = 1'b1;
    b_bad = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.asel == SELW'(k)) begin
        aval  = bus.src_bus[k*WIDTH +: WIDTH];
        a_ok  = bus.src_valid[k];
        a_bad = 1'b0;
      end
      if (bus.bsel == SELW'(k)) begin
        bval  = bus.src_bus[k*WIDTH +: WIDTH];
        b_ok  = bus.src_valid[k];
        b_bad = 1'b0;
      end
    end
  end

  assign srcs_ok = a_ok & b_ok;
  assign space   = ~ov_q | bus.out_ready;
  assign accept  = bus.in_valid & space & srcs_ok;
  assign stall   = bus.in_valid & space & ~srcs_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ain_q <= '0;
      bin_q <= '0;
      ov_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      ain_q <= bus.swap ? bval : aval;
      bin_q <= bus.swap ? aval : bval;
      ov_q  <= 1'b1;
      err_q <= a_bad | b_bad;
    end else if (bus.out_ready) begin
      ov_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      stall_cnt <= cnt_d;
    end
  end

  // Backpressure alone falls through to default and holds the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = stall_cnt;
    unique case (1'b1)
      (!bus.in_valid || accept): begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      stall: begin
        state_d = STALL;
        if (state_q == IDLE)
          cnt_d = CNTW'(1);
        else if (stall_cnt != CMAX)
          cnt_d = stall_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready      = space & srcs_ok;
  assign bus.ain           = ain_q;
  assign bus.bin           = bin_q;
  assign bus.out_valid     = ov_q;
  assign bus.sel_err       = err_q;
  assign bus.stall_timeout = stall_cnt >= LIMIT;

endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage: directed scenarios then random
// traffic on two configurations, checked against a behavioural model.
module tb_operand_select_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_select_stage_if #(.WIDTH(16), .NSRC(4)) i0 ();
  operand_select_stage_if #(.WIDTH(16), .NSRC(3)) i1 ();

  operand_select_stage #(
    .WIDTH(16), .NSRC(4), .CNTW(8), .STALL_LIMIT(64)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));

  operand_select_stage #(
    .WIDTH(16), .NSRC(3), .CNTW(4), .STALL_LIMIT(10)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  typedef struct {
    int ain;
    int bin;
    bit ov;
    bit err;
    int cnt;
  } mdl_t;

  mdl_t        m [2];
  logic [15:0] s [2][4];
  bit          v [2][4];
  int          as [2];
  int          bs [2];
  bit          sw [2];
  bit          iv [2];
  bit          ordy [2];

  int tests = 0;
  int fails = 0;

  function automatic int nsrc(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int cmax(int d);
    return (d == 0) ? 255 : 15;
  endfunction

  function automatic int lim(int d);
    return (d == 0) ? 64 : 10;
  endfunction

  function automatic int val(int d, int sel);
    return (sel >= nsrc(d)) ? 0 : int'(s[d][sel]);
  endfunction

  function automatic bit ok(int d, int sel);
    return (sel >= nsrc(d)) ? 1'b1 : v[d][sel];
  endfunction

  function automatic bit m_space(int d);
    return !m[d].ov || ordy[d];
  endfunction

  function automatic bit m_rdy(int d);
    return m_space(d) && ok(d, as[d]) && ok(d, bs[d]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(int d, logic [15:0] a, logic [15:0] b,
                         logic ov, logic err, logic to, logic rdy,
                         logic [7:0] cnt);
    chk($sformatf("u%0d.ain", d), 32'(a), m[d].ain);
    chk($sformatf("u%0d.bin", d), 32'(b), m[d].bin);
    chk($sformatf("u%0d.out_valid", d), 32'(ov), 32'(m[d].ov));
    chk($sformatf("u%0d.sel_err", d), 32'(err), 32'(m[d].err));
    chk($sformatf("u%0d.stall_timeout", d), 32'(to),
        32'(m[d].cnt >= lim(d)));
    chk($sformatf("u%0d.in_ready", d), 32'(rdy), 32'(m_rdy(d)));
    chk($sformatf("u%0d.stall_cnt", d), 32'(cnt), m[d].cnt);
  endtask

  task automatic upd(int d);
    int  a, b, nc;
    bit  okk, sp, acc;
    a   = val(d, as[d]);
    b   = val(d, bs[d]);
    okk = ok(d, as[d]) && ok(d, bs[d]);
    sp  = m_space(d);
    acc = iv[d] && sp && okk;
    if (!rst_n) begin
      m[d] = '{0, 0, 1'b0, 1'b0, 0};
    end else begin
      if (acc) begin
        m[d].ain = sw[d] ? b : a;
        m[d].bin = sw[d] ? a : b;
        m[d].ov  = 1'b1;
        m[d].err = (as[d] >= nsrc(d)) || (bs[d] >= nsrc(d));
      end else if (m[d].ov && ordy[d]) begin
        m[d].ov = 1'b0;
      end
      if (!iv[d] || acc) begin
        m[d].cnt = 0;
      end else if (sp && !okk) begin
        nc = m[d].cnt + 1;
        m[d].cnt = (nc > cmax(d)) ? cmax(d) : nc;
      end
    end
  endtask

  task automatic apply();
    i0.src_bus   = {s[0][3], s[0][2], s[0][1], s[0][0]};
    i0.src_valid = {v[0][3], v[0][2], v[0][1], v[0][0]};
    i0.asel      = 2'(as[0]);
    i0.bsel      = 2'(bs[0]);
    i0.swap      = sw[0];
    i0.in_valid  = iv[0];
    i0.out_ready = ordy[0];
    i1.src_bus   = {s[1][2], s[1][1], s[1][0]};
    i1.src_valid = {v[1][2], v[1][1], v[1][0]};
    i1.asel      = 2'(as[1]);
    i1.bsel      = 2'(bs[1]);
    i1.swap      = sw[1];
    i1.in_valid  = iv[1];
    i1.out_ready = ordy[1];
  endtask

  // Apply inputs, check at negedge, advance model, land 1ns past posedge.
  task automatic tick();
    apply();
    @(negedge clk);
    chk_dut(0, i0.ain, i0.bin, i0.out_valid, i0.sel_err,
            i0.stall_timeout, i0.in_ready, u0.stall_cnt);
    chk_dut(1, i1.ain, i1.bin, i1.out_valid, i1.sel_err,
            i1.stall_timeout, i1.in_ready, 8'(u1.stall_cnt));
    upd(0);
    upd(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m[d] = '{0, 0, 1'b0, 1'b0, 0};
      for (int k = 0; k < 4; k++) begin
        s[d][k] = 16'(16'h1111 * (k + 1));
        v[d][k] = 1'b1;
      end
      as[d] = 0; bs[d] = 0; sw[d] = 0;
      iv[d] = 0; ordy[d] = 1;
    end
    apply();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Basic select and swap on the 4-source unit
    as[0] = 2; bs[0] = 0; iv[0] = 1;
    tick();
    chk("sel_ain", 32'(i0.ain), 32'h3333);
    chk("sel_bin", 32'(i0.bin), 32'h1111);
    sw[0] = 1;
    tick();
    chk("swap_ain", 32'(i0.ain), 32'h1111);
    chk("swap_bin", 32'(i0.bin), 32'h3333);

    // Backpressure freezes the pair, release replaces with no bubble
    sw[0] = 0; as[0] = 1; bs[0] = 3; ordy[0] = 0;
    repeat (5) tick();
    chk("bp_ain", 32'(i0.ain), 32'h1111);
    chk("bp_ready", 32'(i0.in_ready), 32'h0);
    ordy[0] = 1;
    tick();
    chk("bp_new_ain", 32'(i0.ain), 32'h2222);
    chk("bp_new_bin", 32'(i0.bin), 32'h4444);
    chk("bp_new_ov", 32'(i0.out_valid), 32'h1);

    // Stall on an unready source until the timeout threshold
    v[0][1] = 0; as[0] = 1; bs[0] = 0;
    repeat (63) tick();
    chk("stall63_to", 32'(i0.stall_timeout), 32'h0);
    tick();
    chk("stall64_to", 32'(i0.stall_timeout), 32'h1);
    repeat (6) tick();
    chk("stall70_cnt", 32'(u0.stall_cnt), 32'd70);
    v[0][1] = 1;
    tick();
    chk("unstall_cnt", 32'(u0.stall_cnt), 32'd0);
    chk("unstall_to", 32'(i0.stall_timeout), 32'h0);
    chk("unstall_ov", 32'(i0.out_valid), 32'h1);
    iv[0] = 0;

    // Saturation on the 4-bit counter
    v[1][1] = 0; as[1] = 1; bs[1] = 0; iv[1] = 1;
    repeat (20) tick();
    chk("sat_cnt", 32'(u1.stall_cnt), 32'd15);
    chk("sat_to", 32'(i1.stall_timeout), 32'h1);
    v[1][1] = 1;

    // Out-of-range select on the 3-source unit
    as[1] = 3; bs[1] = 0;
    tick();
    chk("oor_ain", 32'(i1.ain), 32'h0);
    chk("oor_bin", 32'(i1.bin), 32'h1111);
    chk("oor_err", 32'(i1.sel_err), 32'h1);
    as[1] = 2;
    tick();
    chk("oor_clr", 32'(i1.sel_err), 32'h0);

    // Asynchronous reset while a pair is held
    rst_n = 1'b0;
    #1;
    chk("rst_ov", 32'(i1.out_valid), 32'h0);
    chk("rst_ain", 32'(i1.ain), 32'h0);
    chk("rst_bin", 32'(i1.bin), 32'h0);
    chk("rst_err", 32'(i1.sel_err), 32'h0);
    for (int d = 0; d < 2; d++) m[d] = '{0, 0, 1'b0, 1'b0, 0};
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ov", 32'(i1.out_valid), 32'h1);

    // Random traffic on both units
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          s[d][k] = 16'($urandom);
          v[d][k] = ($urandom_range(0, 3) != 0);
        end
        as[d]   = $urandom_range(0, 3);
        bs[d]   = $urandom_range(0, 3);
        sw[d]   = $urandom_range(0, 1) != 0;
        iv[d]   = $urandom_range(0, 4) != 0;
        ordy[d] = $urandom_range(0, 2) != 0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
